// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Write-port controller for the general-purpose register file (r0..r14).
// After reset it clears every register to INIT_VALUE, one index per cycle.
// It then shares the single write port between two writeback requesters
// using a round-robin valid/ready handshake with registered write outputs.
//
// Ports
//   clk           clock, all state updates on the rising edge
//   rst           synchronous active-high reset
//   req0_valid    EXE/ALU writeback request
//   req0_dest     EXE destination index
//   req0_data     EXE writeback data
//   req0_ready    EXE request accepted this cycle (combinational)
//   req1_valid    MEM/load writeback request
//   req1_dest     MEM destination index
//   req1_data     MEM writeback data
//   req1_ready    MEM request accepted this cycle (combinational)
//   wb_en         register-file write enable (registered)
//   wb_dest       register-file write index (registered)
//   wb_data       register-file write data (registered)
//   init_done     high once the clear sequence has completed (registered)
//   illegal_dest  one-cycle pulse when an accepted request targets >= NUM_REGS
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int          NUM_REGS   = 15,
    parameter logic [31:0] INIT_VALUE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [3:0]  req0_dest,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [3:0]  req1_dest,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
    output logic        wb_en,
    output logic [3:0]  wb_dest,
    output logic [31:0] wb_data,
    output logic        init_done,
    output logic        illegal_dest
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [3:0] LAST_IDX   = 4'(NUM_REGS - 1);
    localparam logic [4:0] NUM_REGS_W = 5'(NUM_REGS);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [3:0]  cnt_r;
    logic [3:0]  cnt_nxt_s;
    logic        last_grant_r;
    logic        last_grant_nxt_s;

    logic        wb_en_nxt_s;
    logic [3:0]  wb_dest_nxt_s;
    logic [31:0] wb_data_nxt_s;
    logic        init_done_nxt_s;
    logic        illegal_nxt_s;

    logic        ready0_s;
    logic        ready1_s;
    logic        xfer_s;
    logic [3:0]  sel_dest_s;
    logic [31:0] sel_data_s;

    // Round-robin grant: depends only on state, the valids and last_grant.
    always_comb begin
        ready0_s = 1'b0;
        ready1_s = 1'b0;
        if (state_r == ST_RUN) begin
            if (req0_valid && req1_valid) begin
                // On a tie, the requester that did not win last time goes now.
                ready0_s = last_grant_r;
                ready1_s = ~last_grant_r;
            end else begin
                ready0_s = req0_valid;
                ready1_s = req1_valid;
            end
        end else begin
            ready0_s = 1'b0;
            ready1_s = 1'b0;
        end
    end

    assign req0_ready = ready0_s;
    assign req1_ready = ready1_s;

    // Select the payload of whichever requester was granted.
    always_comb begin
        xfer_s     = ready0_s | ready1_s;
        sel_dest_s = 4'd0;
        sel_data_s = 32'h0000_0000;
        if (ready0_s) begin
            sel_dest_s = req0_dest;
            sel_data_s = req0_data;
        end else begin
            sel_dest_s = req1_dest;
            sel_data_s = req1_data;
        end
    end

    // Next-state and next-output logic for the INIT/RUN sequencer.
    always_comb begin
        state_nxt_s      = state_r;
        cnt_nxt_s        = cnt_r;
        last_grant_nxt_s = last_grant_r;
        wb_en_nxt_s      = 1'b0;
        wb_dest_nxt_s    = wb_dest;
        wb_data_nxt_s    = wb_data;
        init_done_nxt_s  = init_done;
        illegal_nxt_s    = 1'b0;
        case (state_r)
            ST_INIT: begin
                wb_en_nxt_s   = 1'b1;
                wb_dest_nxt_s = cnt_r;
                wb_data_nxt_s = INIT_VALUE;
                if (cnt_r == LAST_IDX) begin
                    // Last clear write issues on the same edge init_done rises.
                    state_nxt_s     = ST_RUN;
                    cnt_nxt_s       = 4'd0;
                    init_done_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s       = cnt_r + 4'd1;
                    init_done_nxt_s = 1'b0;
                end
            end
            ST_RUN: begin
                init_done_nxt_s = 1'b1;
                if (xfer_s) begin
                    last_grant_nxt_s = ready1_s;
                    if ({1'b0, sel_dest_s} >= NUM_REGS_W) begin
                        // Accepted but dropped: index 15 is the PC slot.
                        wb_en_nxt_s   = 1'b0;
                        illegal_nxt_s = 1'b1;
                    end else begin
                        wb_en_nxt_s   = 1'b1;
                        wb_dest_nxt_s = sel_dest_s;
                        wb_data_nxt_s = sel_data_s;
                    end
                end else begin
                    last_grant_nxt_s = last_grant_r;
                    wb_en_nxt_s      = 1'b0;
                end
            end
            default: begin
                // Unreachable encoding: fall back to a fresh clear sequence.
                state_nxt_s     = ST_INIT;
                cnt_nxt_s       = 4'd0;
                init_done_nxt_s = 1'b0;
            end
        endcase
    end

    // State, counter, arbitration history and registered write-port outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_INIT;
            cnt_r        <= 4'd0;
            last_grant_r <= 1'b1;
            wb_en        <= 1'b0;
            wb_dest      <= 4'd0;
            wb_data      <= 32'h0000_0000;
            init_done    <= 1'b0;
            illegal_dest <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            last_grant_r <= last_grant_nxt_s;
            wb_en        <= wb_en_nxt_s;
            wb_dest      <= wb_dest_nxt_s;
            wb_data      <= wb_data_nxt_s;
            init_done    <= init_done_nxt_s;
            illegal_dest <= illegal_nxt_s;
        end
    end

endmodule
